// File: rtl/reg3_pkg.sv
// Shared constants for the 3-bit register serial front end:
// register width, command opcodes and loader FSM state encoding.
package reg3_pkg;

   localparam int REG_W = 3;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b01;
   localparam logic [1:0] OP_CLR  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_OP        = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PAR       = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/register3_bit.sv
// Parallel-write 3-bit register driven by the serial loader.
// Clear has priority over set (value 1), which has priority over load.
module register3_bit
   import reg3_pkg::*;
#(
   parameter int WIDTH = REG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   input  logic             set,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (set)
         q <= WIDTH'(1);
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/ser_shift_cap.sv
// LSB-first serial capture: N-bit shift register with a bit counter.
// done is high on the shift that brings in the N-th bit.
module ser_shift_cap #(
   parameter int N  = 5,
   parameter int CW = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         shift,
   input  logic         din,
   output logic [N-1:0] data,
   output logic         done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data <= '0;
         cnt  <= '0;
      end else if (clr) begin
         data <= '0;
         cnt  <= '0;
      end else if (shift) begin
         // first bit received ends up in data[0]
         data <= {din, data[N-1:1]};
         cnt  <= cnt + 1'b1;
      end
   end

   assign done = shift && (cnt == CW'(N - 1));

endmodule

// File: rtl/reg3_serial_loader.sv
// Serial command front end: decodes start/op/data/parity/stop frames into
// single-cycle write pulses for register3_bit. All outputs are flopped.
module reg3_serial_loader
   import reg3_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_en,
   input  logic             ser_in,
   output logic [WIDTH-1:0] reg_in,
   output logic             reg_load,
   output logic             reg_set,
   output logic             reg_clr,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err,
   output logic             cmd_err
);

   localparam int CAP_N  = WIDTH + 2;
   localparam int CAP_CW = $clog2(CAP_N);

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] bit_cnt;
   logic             par_acc;
   logic             cap_clr;
   logic             cap_shift;
   logic             cap_done;
   logic [CAP_N-1:0] cap_data;
   logic [1:0]       cap_op;
   logic [WIDTH-1:0] cap_val;

   ser_shift_cap #(
      .N  (CAP_N),
      .CW (CAP_CW)
   ) u_cap (
      .clock (clock),
      .reset (reset),
      .clr   (cap_clr),
      .shift (cap_shift),
      .din   (ser_in),
      .data  (cap_data),
      .done  (cap_done)
   );

   assign cap_op  = cap_data[1:0];
   assign cap_val = cap_data[WIDTH+1:2];

   always_comb begin
      state_next = state;
      cap_clr    = 1'b0;
      cap_shift  = 1'b0;
      if (bit_en) begin
         case (state)
            S_IDLE: begin
               if (!ser_in) begin
                  state_next = S_OP;
                  cap_clr    = 1'b1;
               end
            end
            S_OP: begin
               cap_shift = 1'b1;
               if (bit_cnt == CNT_W'(1))
                  state_next = S_DATA;
            end
            S_DATA: begin
               cap_shift = 1'b1;
               if (cap_done)
                  state_next = S_PAR;
            end
            S_PAR:       state_next = S_STOP;
            S_STOP:      state_next = ser_in ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (ser_in) state_next = S_IDLE;
            default:     state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         par_acc    <= 1'b0;
         reg_in     <= '0;
         reg_load   <= 1'b0;
         reg_set    <= 1'b0;
         reg_clr    <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != S_IDLE);
         reg_load   <= 1'b0;
         reg_set    <= 1'b0;
         reg_clr    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         cmd_err    <= 1'b0;
         if (bit_en) begin
            case (state)
               S_IDLE: begin
                  bit_cnt <= '0;
                  par_acc <= 1'b0;
               end
               S_OP: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  par_acc <= par_acc ^ ser_in;
               end
               S_DATA, S_PAR: par_acc <= par_acc ^ ser_in;
               S_STOP: begin
                  // a bad stop bit overrides parity and opcode checks
                  if (!ser_in)
                     frame_err <= 1'b1;
                  else if (par_acc)
                     parity_err <= 1'b1;
                  else begin
                     case (cap_op)
                        OP_LOAD: begin
                           reg_load <= 1'b1;
                           reg_in   <= cap_val;
                        end
                        OP_SET:  reg_set <= 1'b1;
                        OP_CLR:  reg_clr <= 1'b1;
                        default: cmd_err <= 1'b1;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
